ah_packet_converter_n2w: RTL and testbench



---
 rtl/ah_pkt_pkg.sv | 26 ++
 rtl/ah_gbx_shift_buf.sv | 64 ++++++
 rtl/ah_packet_converter_n2w.sv | 87 ++++++++
 tb/tb_ah_packet_converter_n2w.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ah_pkt_pkg.sv
// Shared types and constants for the packet converter family (narrow/wide gearboxes).
package ah_pkt_pkg;

  // Default link widths shared by the wide-to-narrow and narrow-to-wide converters.
  localparam int AH_NARROW_W = 10;
  localparam int AH_WIDE_W   = 15;

  // Gearbox FSM: FILL accepts beats; DRAIN empties the tail of a packet.
  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } ah_gbx_state_t;

  // Ceiling log2 usable in constant expressions; returns 0 for values <= 1.
  function automatic int ah_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << result) < 64'(value)) begin
        result = result + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/ah_gbx_shift_buf.sv
// Accumulation buffer for the narrow-to-wide gearbox. Holds the packed bits and
// their count, shifting a word out at the bottom and inserting a beat at the
// current fill offset, both in the same cycle when requested.
module ah_gbx_shift_buf
  import ah_pkt_pkg::*;
#(
  parameter int IN_W   = AH_NARROW_W,
  parameter int OUT_W  = AH_WIDE_W,
  parameter int BUF_W  = IN_W + OUT_W - 1,
  parameter int FILL_W = ah_clog2(BUF_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [IN_W-1:0]   rdata,
  output logic [BUF_W-1:0]  buf_data,
  output logic [FILL_W-1:0] fill
);

  localparam logic [FILL_W-1:0] IN_W_F  = FILL_W'(IN_W);
  localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);

  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [BUF_W-1:0]  buf_after_pop;
  logic [FILL_W-1:0] fill_after_pop;

  // Next buffer contents: retire a word first, then append the beat above what remains.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    buf_after_pop  = buf_q;
    fill_after_pop = fill_q;
    if (pop) begin
      // The final word of a packet may be short; the buffer empties completely.
      fill_after_pop = (fill_q > OUT_W_F) ? (fill_q - OUT_W_F) : '0;
      buf_after_pop  = buf_q >> OUT_W;
    end

    buf_d  = buf_after_pop;
    fill_d = fill_after_pop;
    if (push) begin
      // Bits above the fill point are zero, so OR-ing the beat in is an insert.
      buf_d  = buf_after_pop | (BUF_W'(rdata) << fill_after_pop);
      fill_d = fill_after_pop + IN_W_F;
    end
  end

  // Buffer and fill registers; synchronous reset empties the buffer.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (rst) begin
      buf_q  <= '0;
      fill_q <= '0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
    end
  end

  assign buf_data = buf_q;
  assign fill     = fill_q;

endmodule

// File: rtl/ah_packet_converter_n2w.sv
// Narrow-to-wide packet gearbox: packs IN_W-bit beats LSB-first into OUT_W-bit
// words. A packet's last word is zero-padded and flagged with wlast, and the
// next packet always starts on a fresh word.
module ah_packet_converter_n2w
  import ah_pkt_pkg::*;
#(
  parameter int IN_W  = AH_NARROW_W,
  parameter int OUT_W = AH_WIDE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  rdata,
  input  logic             rvalid,
  input  logic             rlast,
  output logic             rready,
  output logic [OUT_W-1:0] wdata,
  output logic             wvalid,
  output logic             wlast,
  input  logic             wready
);

  localparam int BUF_W  = IN_W + OUT_W - 1;
  localparam int FILL_W = ah_clog2(BUF_W + 1);

  // Highest fill at which a whole beat still fits in the buffer.
  localparam logic [FILL_W-1:0] RREADY_MAX = FILL_W'(BUF_W - IN_W);
  localparam logic [FILL_W-1:0] OUT_W_F    = FILL_W'(OUT_W);

  ah_gbx_state_t     state_q, state_d;
  logic [BUF_W-1:0]  buf_data;
  logic [FILL_W-1:0] fill;
  logic              push;
  logic              pop;

  ah_gbx_shift_buf #(
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .BUF_W  (BUF_W),
    .FILL_W (FILL_W)
  ) u_shift_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .rdata    (rdata),
    .buf_data (buf_data),
    .fill     (fill)
  );

  // Handshake outputs from registered state only, plus the FSM next state.
  always_comb begin
    state_d = state_q;
    rready  = 1'b0;
    wvalid  = 1'b0;
    wlast   = 1'b0;
    wdata   = buf_data[OUT_W-1:0];

    // No new beats are taken while a packet tail drains, keeping packets apart.
    rready = (state_q == FILL) && (fill <= RREADY_MAX);

    if (state_q == FILL) begin
      wvalid = (fill >= OUT_W_F);
    end else begin
      wvalid = (fill != '0);
      wlast  = (fill <= OUT_W_F);
    end

    push = rvalid && rready;
    pop  = wvalid && wready;

    case (state_q)
      FILL:    if (push && rlast) state_d = DRAIN;
      DRAIN:   if (pop && wlast)  state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_ah_packet_converter_n2w.sv
// Directed bench for the narrow-to-wide packet gearbox (IN_W=10, OUT_W=15).
module tb_ah_packet_converter_n2w;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rdata;
  logic        rvalid;
  logic        rlast;
  logic        rready;
  logic [14:0] wdata;
  logic        wvalid;
  logic        wlast;
  logic        wready;

  int tests_run    = 0;
  int tests_failed = 0;

  ah_packet_converter_n2w #(
    .IN_W  (10),
    .OUT_W (15)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rdata  (rdata),
    .rvalid (rvalid),
    .rlast  (rlast),
    .rready (rready),
    .wdata  (wdata),
    .wvalid (wvalid),
    .wlast  (wlast),
    .wready (wready)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled and inputs driven 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic v, input logic [9:0] d, input logic l);
    rvalid = v;
    rdata  = d;
    rlast  = l;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [9:0]  beats [6];
  logic [59:0] collected;
  logic [59:0] expected60;
  int          idx;
  int          nwords;
  int          mfill;
  int          bad_rready;
  logic        do_push;
  logic        do_pop;

  initial begin
    rst = 1'b1;
    wready = 1'b0;
    drive(1'b0, 10'h000, 1'b0);
    repeat (2) cyc();
    rst = 1'b0;

    // Reset state
    check("reset_wvalid", wvalid, 1'b0);
    check("reset_wlast",  wlast,  1'b0);
    check("reset_wdata",  wdata,  15'h0000);
    check("reset_rready", rready, 1'b1);

    // Exact fit: 0x155, 0x2AA, 0x0F0+rlast -> 0x2955, 0x1E15(last)
    wready = 1'b1;
    drive(1'b1, 10'h155, 1'b0);
    cyc();
    check("fit_wvalid_after_1", wvalid, 1'b0);
    drive(1'b1, 10'h2AA, 1'b0);
    cyc();
    check("fit_w0_wvalid", wvalid, 1'b1);
    check("fit_w0_wdata",  wdata,  15'h2955);
    check("fit_w0_wlast",  wlast,  1'b0);
    check("fit_full_rready", rready, 1'b0);
    drive(1'b1, 10'h0F0, 1'b1);
    cyc();
    check("fit_rready_after_pop", rready, 1'b1);
    check("fit_wvalid_fill5", wvalid, 1'b0);
    cyc();
    drive(1'b0, 10'h000, 1'b0);
    check("fit_w1_wvalid", wvalid, 1'b1);
    check("fit_w1_wdata",  wdata,  15'h1E15);
    check("fit_w1_wlast",  wlast,  1'b1);
    check("fit_drain_rready", rready, 1'b0);
    cyc();
    check("fit_done_wvalid", wvalid, 1'b0);
    check("fit_done_wlast",  wlast,  1'b0);
    check("fit_done_rready", rready, 1'b1);

    // Padding: single beat 0x3FF+rlast -> 0x03FF(last)
    drive(1'b1, 10'h3FF, 1'b1);
    cyc();
    drive(1'b0, 10'h000, 1'b0);
    check("pad_wvalid", wvalid, 1'b1);
    check("pad_wdata",  wdata,  15'h03FF);
    check("pad_wlast",  wlast,  1'b1);
    cyc();
    check("pad_after_wvalid", wvalid, 1'b0);
    check("pad_after_wdata",  wdata,  15'h0000);
    check("pad_after_rready", rready, 1'b1);

    // Backpressure: wready=0 while beats 0x001, 0x002, ... are offered
    wready = 1'b0;
    drive(1'b1, 10'h001, 1'b0);
    cyc();
    check("bp_rready_fill10", rready, 1'b1);
    drive(1'b1, 10'h002, 1'b0);
    cyc();
    check("bp_rready_fill20", rready, 1'b0);
    check("bp_wvalid", wvalid, 1'b1);
    check("bp_wdata",  wdata,  15'h0801);
    drive(1'b1, 10'h003, 1'b0);
    repeat (2) begin
      cyc();
      check("bp_hold_wdata",  wdata,  15'h0801);
      check("bp_hold_wvalid", wvalid, 1'b1);
      check("bp_hold_wlast",  wlast,  1'b0);
      check("bp_hold_rready", rready, 1'b0);
    end
    wready = 1'b1;
    cyc();
    check("bp_release_wvalid", wvalid, 1'b0);
    check("bp_release_rready", rready, 1'b1);
    cyc();
    drive(1'b1, 10'h004, 1'b0);
    check("bp_w1_wdata",  wdata,  15'h0060);
    check("bp_w1_wvalid", wvalid, 1'b1);
    check("bp_w1_rready", rready, 1'b0);
    cyc();
    check("bp_empty_rready", rready, 1'b1);
    check("bp_empty_wvalid", wvalid, 1'b0);
    cyc();
    drive(1'b1, 10'h005, 1'b1);
    check("bp_fill10_wvalid", wvalid, 1'b0);
    cyc();
    drive(1'b0, 10'h000, 1'b0);
    check("bp_w2_wdata",  wdata,  15'h1404);
    check("bp_w2_wlast",  wlast,  1'b0);
    cyc();
    check("bp_w3_wvalid", wvalid, 1'b1);
    check("bp_w3_wdata",  wdata,  15'h0000);
    check("bp_w3_wlast",  wlast,  1'b1);
    cyc();
    check("bp_done_wvalid", wvalid, 1'b0);
    check("bp_done_rready", rready, 1'b1);

    // Streaming: 6 beats, no rlast, wready=1 -> 4 words, 60 bits in order
    beats[0] = 10'h123; beats[1] = 10'h3A5; beats[2] = 10'h0F1;
    beats[3] = 10'h2C7; beats[4] = 10'h155; beats[5] = 10'h388;
    expected60 = '0;
    for (int i = 0; i < 6; i++) expected60 = expected60 | (60'(beats[i]) << (10 * i));
    collected  = '0;
    idx        = 0;
    nwords     = 0;
    mfill      = 0;
    bad_rready = 0;
    wready     = 1'b1;
    for (int c = 0; c < 40 && (idx < 6 || nwords < 4); c++) begin
      if (idx < 6) drive(1'b1, beats[idx], 1'b0);
      else         drive(1'b0, 10'h000, 1'b0);
      if (rready !== (mfill <= 14)) bad_rready++;
      do_push = rvalid && rready;
      do_pop  = wvalid && wready;
      if (do_pop && nwords < 4) begin
        collected = collected | (60'(wdata) << (15 * nwords));
      end
      if (do_pop) nwords++;
      if (do_pop) mfill = (mfill > 15) ? mfill - 15 : 0;
      if (do_push) begin
        mfill = mfill + 10;
        idx++;
      end
      cyc();
    end
    drive(1'b0, 10'h000, 1'b0);
    check("stream_word_count", nwords, 4);
    check("stream_bits", collected, expected60);
    check("stream_rready_vs_fill", bad_rready, 0);
    check("stream_end_wvalid", wvalid, 1'b0);
    check("stream_end_rready", rready, 1'b1);

    // Mid-packet reset: one beat pushed, then reset
    drive(1'b1, 10'h2AB, 1'b0);
    cyc();
    drive(1'b0, 10'h000, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mrst_wvalid", wvalid, 1'b0);
    check("mrst_wlast",  wlast,  1'b0);
    check("mrst_wdata",  wdata,  15'h0000);
    check("mrst_rready", rready, 1'b1);
    drive(1'b1, 10'h3FF, 1'b1);
    cyc();
    drive(1'b0, 10'h000, 1'b0);
    check("mrst_next_wdata", wdata, 15'h03FF);
    check("mrst_next_wlast", wlast, 1'b1);
    cyc();
    check("mrst_next_done", wvalid, 1'b0);

    // Back-to-back packets: A = 0x111+rlast; B = 0x222, 0x333+rlast
    drive(1'b1, 10'h111, 1'b1);
    cyc();
    drive(1'b1, 10'h222, 1'b0);
    check("b2b_a_rready", rready, 1'b0);
    check("b2b_a_wdata",  wdata,  15'h0111);
    check("b2b_a_wlast",  wlast,  1'b1);
    cyc();
    check("b2b_gap_rready", rready, 1'b1);
    check("b2b_gap_wvalid", wvalid, 1'b0);
    cyc();
    drive(1'b1, 10'h333, 1'b1);
    check("b2b_b1_wvalid", wvalid, 1'b0);
    cyc();
    drive(1'b0, 10'h000, 1'b0);
    check("b2b_b_w0_wdata", wdata, 15'h4E22);
    check("b2b_b_w0_wlast", wlast, 1'b0);
    check("b2b_b_rready",   rready, 1'b0);
    cyc();
    check("b2b_b_w1_wvalid", wvalid, 1'b1);
    check("b2b_b_w1_wdata",  wdata,  15'h0019);
    check("b2b_b_w1_wlast",  wlast,  1'b1);
    cyc();
    check("b2b_done_wvalid", wvalid, 1'b0);
    check("b2b_done_wlast",  wlast,  1'b0);
    check("b2b_done_rready", rready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
